// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending controller slice:
//   - state_t         controller FSM states
//   - *_VAL           coin values in nickels
//   - DEFAULT_PRICES  packed per-item prices in nickels, item 0 in the LSB byte
//   - coin_value()    nickel value of a coin vector (0 when not exactly one-hot)
//   - is_onehot32()   exactly-one-bit-set test for vectors up to 32 bits
// -----------------------------------------------------------------------------
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // no credit held
    CREDIT = 2'd1,  // credit held, waiting for coins / selection
    VEND   = 2'd2,  // one-cycle dispense pulse
    CHANGE = 2'd3   // returning one nickel per cycle
  } state_t;

  localparam logic [2:0] NICKEL_VAL  = 3'd1;
  localparam logic [2:0] DIME_VAL    = 3'd2;
  localparam logic [2:0] QUARTER_VAL = 3'd5;

  // 15/20/25/30 cents for items 0..3.
  localparam logic [31:0] DEFAULT_PRICES = {8'd6, 8'd5, 8'd4, 8'd3};

  function automatic logic is_onehot32(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

  // Coin bit 0 = nickel, 1 = dime, 2 = quarter. Anything that is not a
  // single coin is worth nothing and gets rejected by the caller.
  function automatic logic [2:0] coin_value(input logic [2:0] coin);
    logic [2:0] val;
    unique case (coin)
      3'b001:  val = NICKEL_VAL;
      3'b010:  val = DIME_VAL;
      3'b100:  val = QUARTER_VAL;
      default: val = 3'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vend_ctrl_param_if.sv
// -----------------------------------------------------------------------------
// vend_ctrl_param_if
// Bundles the front-end inputs and dispenser/display outputs of the vending
// controller.
//   master : coin/keypad side  - drives coin, item_sel, cancel
//   slave  : the controller    - drives item_dispense, change_nickel,
//            coin_reject, sold_out, busy, left_display, right_display
// -----------------------------------------------------------------------------
interface vend_ctrl_param_if #(
  parameter int N_ITEMS = 4
);
  logic [2:0]         coin;
  logic [N_ITEMS-1:0] item_sel;
  logic               cancel;
  logic [N_ITEMS-1:0] item_dispense;
  logic               change_nickel;
  logic               coin_reject;
  logic [N_ITEMS-1:0] sold_out;
  logic               busy;
  logic [7:0]         left_display;
  logic [7:0]         right_display;

  modport master (
    output coin, item_sel, cancel,
    input  item_dispense, change_nickel, coin_reject, sold_out, busy,
           left_display, right_display
  );

  modport slave (
    input  coin, item_sel, cancel,
    output item_dispense, change_nickel, coin_reject, sold_out, busy,
           left_display, right_display
  );
endinterface

// File: rtl/vend_ctrl_param_nickel_to_bcd.sv
// -----------------------------------------------------------------------------
// nickel_to_bcd
// Combinational: nickel count -> two-digit BCD cents.
//   nickels in  5  amount in nickels (0..19 gives a valid 0..95 cents result)
//   bcd     out 8  {tens, ones} BCD cents
// Since cents = 5*n, the tens digit is n/2 and the ones digit is 5 when n is
// odd, 0 otherwise -- no divider needed.
// -----------------------------------------------------------------------------
module nickel_to_bcd (
  input  logic [4:0] nickels,
  output logic [7:0] bcd
);
  assign bcd = {nickels[4:1], (nickels[0] ? 4'd5 : 4'd0)};
endmodule

// File: rtl/vend_ctrl_param.sv
// -----------------------------------------------------------------------------
// vend_ctrl_param
// Multi-item, stock-aware vending controller. Accepts one-hot coin pulses,
// holds credit in nickels, latches a one-hot selection and vends as soon as
// the credit covers the price. Change is paid one nickel per cycle.
//   clk    in  clock
//   reset  in  asynchronous active-high reset (credit lost, stock reloaded)
//   bus    slave side of vend_ctrl_param_if (coin/item_sel/cancel in;
//          item_dispense, change_nickel, coin_reject, sold_out, busy,
//          left_display, right_display out)
// -----------------------------------------------------------------------------
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int                   N_ITEMS    = 4,
  parameter logic [8*N_ITEMS-1:0] PRICES     = DEFAULT_PRICES,
  parameter int                   MAX_CREDIT = 19,
  parameter int                   STOCK_W    = 4,
  parameter int                   INIT_STOCK = 5
) (
  input logic              clk,
  input logic              reset,
  vend_ctrl_param_if.slave bus
);

  state_t             state_q, state_d;
  logic [4:0]         credit_q, credit_d;
  logic [N_ITEMS-1:0] sel_q, sel_d;     // latched selection, one-hot or zero
  logic [N_ITEMS-1:0] vend_q, vend_d;   // item being dispensed in VEND
  logic               coin_reject_q, coin_reject_d;
  logic [STOCK_W-1:0] stock_q [N_ITEMS];
  logic [STOCK_W-1:0] stock_d [N_ITEMS];

  logic [2:0] coin_val;
  logic [5:0] credit_sum;
  logic       coin_fits;
  logic [4:0] credit_acc;   // credit after this cycle's coin, before any vend
  logic [4:0] sel_price;
  logic       sel_in_stock;
  logic       new_sel_ok;
  logic       vend_ok;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  assign coin_val   = coin_value(bus.coin);
  assign credit_sum = {1'b0, credit_q} + {3'b000, coin_val};
  assign coin_fits  = (coin_val != 3'd0) && (credit_sum <= 6'(MAX_CREDIT));

  // NOTE: every variable driven here gets a default before any branch, so a
  // missing assignment on some path cannot turn into a latch.
  always_comb begin
    sel_price    = '0;
    sel_in_stock = 1'b0;
    new_sel_ok   = 1'b0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (sel_q[i]) begin
        sel_price    = PRICES[8*i +: 5];
        sel_in_stock = (stock_q[i] != '0);
      end
      if (bus.item_sel[i] && (stock_q[i] != '0)) begin
        new_sel_ok = 1'b1;
      end
    end
    if (!is_onehot32(32'(bus.item_sel))) begin
      new_sel_ok = 1'b0;
    end
  end

  // Vend decision uses registered credit and selection only.
  assign vend_ok = (sel_q != '0) && (credit_q >= sel_price) && sel_in_stock;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    sel_d         = sel_q;
    vend_d        = vend_q;
    stock_d       = stock_q;
    coin_reject_d = 1'b0;
    credit_acc    = credit_q;

    unique case (state_q)
      IDLE, CREDIT: begin
        if (bus.cancel) begin
          // Cancel wins over coin, selection and a pending vend.
          sel_d         = '0;
          coin_reject_d = (bus.coin != '0);
          if (credit_q != '0) begin
            state_d = CHANGE;
          end
        end else begin
          if (bus.coin != '0) begin
            if (coin_fits) begin
              credit_acc = credit_sum[4:0];
            end else begin
              coin_reject_d = 1'b1;
            end
          end

          if (vend_ok) begin
            state_d  = VEND;
            credit_d = credit_acc - sel_price;
            vend_d   = sel_q;
            sel_d    = '0;
            for (int i = 0; i < N_ITEMS; i++) begin
              if (sel_q[i]) begin
                stock_d[i] = stock_q[i] - STOCK_W'(1);
              end
            end
          end else begin
            credit_d = credit_acc;
            if (new_sel_ok) begin
              sel_d = bus.item_sel;
            end
            state_d = (credit_acc != '0) ? CREDIT : IDLE;
          end
        end
      end

      VEND: begin
        coin_reject_d = (bus.coin != '0);
        state_d       = (credit_q != '0) ? CHANGE : IDLE;
      end

      CHANGE: begin
        coin_reject_d = (bus.coin != '0);
        credit_d      = credit_q - 5'd1;
        if (credit_q <= 5'd1) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments keep every register sampling the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      sel_q         <= '0;
      vend_q        <= '0;
      coin_reject_q <= 1'b0;
      // NOTE: the stock array is a handful of flops, not a RAM, and must come
      // back to a known count on reset, so it is reset like any other state.
      for (int i = 0; i < N_ITEMS; i++) begin
        stock_q[i] <= STOCK_W'(INIT_STOCK);
      end
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      sel_q         <= sel_d;
      vend_q        <= vend_d;
      coin_reject_q <= coin_reject_d;
      stock_q       <= stock_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, all decoded from registered state
  // ---------------------------------------------------------------------------
  assign bus.item_dispense = (state_q == VEND) ? vend_q : '0;
  assign bus.change_nickel = (state_q == CHANGE);
  assign bus.busy          = (state_q == VEND) || (state_q == CHANGE);
  assign bus.coin_reject   = coin_reject_q;

  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) begin
      bus.sold_out[i] = (stock_q[i] == '0);
    end
  end

  nickel_to_bcd u_left_bcd (
    .nickels (credit_q),
    .bcd     (bus.left_display)
  );

  nickel_to_bcd u_right_bcd (
    .nickels (sel_price),
    .bcd     (bus.right_display)
  );

endmodule
